// File: rtl/gf2_mat_pkg.sv
// Shared constants, FSM state type and element-index helper for the GF(2) result collector.
package gf2_mat_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = N_DEF * N_DEF;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Flat bit position of matrix element [i][j] in the row-major result word.
  function automatic int idx(input int i, input int j);
    return i * N_DEF + j;
  endfunction

endpackage

// File: rtl/gf2_mat_collect_if.sv
// Serial product input plus parallel result output of the GF(2) collector.
// Optional m_parity signal present when COLLECT_PARITY_EN is defined.
interface gf2_mat_collect_if #(
  parameter int W = 16
);
  // Input stream has no back-pressure: a bit is taken on every edge with bit_valid=1.
  // Output follows valid/ready: m_data transfers on an edge where m_valid and m_ready
  // are both 1; once raised, m_valid and m_data hold until that transfer happens.
  logic         bit_in;
  logic         bit_valid;
  logic         frame_start;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         overflow;
  logic         sync_err;
`ifdef COLLECT_PARITY_EN
  logic         m_parity;

  modport master (
    output bit_in, bit_valid, frame_start, m_ready,
    input  m_data, m_valid, overflow, sync_err, m_parity
  );
  modport slave (
    input  bit_in, bit_valid, frame_start, m_ready,
    output m_data, m_valid, overflow, sync_err, m_parity
  );
`else
  modport master (
    output bit_in, bit_valid, frame_start, m_ready,
    input  m_data, m_valid, overflow, sync_err
  );
  modport slave (
    input  bit_in, bit_valid, frame_start, m_ready,
    output m_data, m_valid, overflow, sync_err
  );
`endif

endinterface

// File: rtl/gf2_bit_shreg.sv
// W-bit capture register: a start clears the word and places the bit at index 0,
// a write places the bit at the given index.
module gf2_bit_shreg #(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [IW-1:0] i_idx,
  input  logic          i_bit,
  output logic [W-1:0]  o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_start) begin
      r_q <= {{(W-1){1'b0}}, i_bit};
    end else if (i_we) begin
      r_q[i_idx] <= i_bit;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gf2_mat_collect.sv
// Assembles the bit-serial GF(2) product into an N*N-bit word behind a one-entry valid/ready output.
// Define COLLECT_PARITY_EN to add the registered m_parity output.
module gf2_mat_collect
  import gf2_mat_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic               clk,
  input  logic               rst,
  gf2_mat_collect_if.slave   bus,
  output state_t             o_dbg_state
);

  localparam int W  = N * N;
  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(W);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_nxt;
  logic           w_start;
  logic           w_we;
  logic           w_load;
  logic           w_ovf_nxt;
  logic           w_serr_nxt;
  logic [W-1:0]   w_q;
  logic [W-1:0]   w_full;
  logic [W-1:0]   r_m_data;
  logic           r_m_valid;
  logic           r_overflow;
  logic           r_sync_err;

  gf2_bit_shreg #(.W(W), .IW(IW)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_we    (w_we),
    .i_idx   (r_count[IW-1:0]),
    .i_bit   (bus.bit_in),
    .o_q     (w_q)
  );

  // The last bit never reaches the capture register; it is merged here on completion.
  // Bit W-1 of w_q is always 0 because a start clears the register.
  assign w_full = w_q | ({{(W-1){1'b0}}, bus.bit_in} << (W - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_start     = 1'b0;
    w_we        = 1'b0;
    w_load      = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_serr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.bit_valid && bus.frame_start) begin
          w_start     = 1'b1;
          w_count_nxt = CW'(1);
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.bit_valid) begin
          if (bus.frame_start) begin
            // A restart wins over completion even when this was the frame's last bit.
            w_start     = 1'b1;
            w_serr_nxt  = 1'b1;
            w_count_nxt = CW'(1);
          end else if (r_count == CW'(W - 1)) begin
            w_count_nxt = '0;
            w_state_nxt = IDLE;
            if (!r_m_valid || bus.m_ready) begin
              w_load = 1'b1;
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end else begin
            w_we        = 1'b1;
            w_count_nxt = r_count + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_overflow <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_ovf_nxt;
      r_sync_err <= w_serr_nxt;
      if (w_load) begin
        r_m_data  <= w_full;
        r_m_valid <= 1'b1;
      end else if (bus.m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef COLLECT_PARITY_EN
  logic r_m_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_parity <= 1'b0;
    end else if (w_load) begin
      r_m_parity <= ^w_full;
    end
  end

  assign bus.m_parity = r_m_parity;
`endif

  assign bus.m_data   = r_m_data;
  assign bus.m_valid  = r_m_valid;
  assign bus.overflow = r_overflow;
  assign bus.sync_err = r_sync_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_gf2_mat_collect.sv
// Directed bench for gf2_mat_collect: drivers push expected words, a negedge monitor drains them.
module tb_gf2_mat_collect;
  import gf2_mat_pkg::*;

  localparam int W = 16;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int ovf_cnt  = 0;
  int serr_cnt = 0;

  gf2_mat_collect_if #(.W(W)) bus ();

  gf2_mat_collect #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b, input logic fs);
    bus.bit_in      = b;
    bus.bit_valid   = 1'b1;
    bus.frame_start = fs;
    @(posedge clk);
    #1;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.bit_in      = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends bits [0 .. nbits-1] of word, frame_start on bit 0, optional gap after bit gap_at.
  task automatic send_frame(input logic [W-1:0] word, input int nbits,
                            input int gap_at, input int gap_len);
    for (int i = 0; i < nbits; i++) begin
      send_bit(word[i], i == 0);
      if (i == gap_at) idle(gap_len);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.overflow) ovf_cnt++;
      if (bus.sync_err) serr_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h expected none", bus.m_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("m_data", 32'(bus.m_data), 32'(e));
`ifdef COLLECT_PARITY_EN
          check("m_parity", 32'(bus.m_parity), 32'(^e));
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ident;
    logic [W-1:0] b2b;
    ident = '0;
    for (int i = 0; i < 4; i++) ident[idx(i, i)] = 1'b1;

    bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.frame_start = 1'b0; bus.m_ready = 1'b0;
    rst = 1'b1;
    do_reset();

    // Reset state
    check("rst_m_valid",  32'(bus.m_valid),  0);
    check("rst_m_data",   32'(bus.m_data),   0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_sync_err", 32'(bus.sync_err), 0);
    check("rst_state",    32'(dbg_state),    32'(IDLE));

    // Identity frame, ready held high: valid for exactly one cycle after the last bit
    bus.m_ready = 1'b1;
    check("ident_word", 32'(ident), 32'h8421);
    exp_q.push_back(16'h8421);
    send_frame(ident, 16, -1, 0);
    check("ident_latency", 32'(bus.m_valid), 1);
`ifdef COLLECT_PARITY_EN
    check("parity_8421", 32'(bus.m_parity), 0);
`endif
    idle(1);
    check("ident_one_cycle", 32'(bus.m_valid), 0);

    // Same frame with a 3-cycle gap after bit 7
    exp_q.push_back(16'h8421);
    send_frame(16'h8421, 16, 7, 3);
    check("gap_latency", 32'(bus.m_valid), 1);
    idle(1);
    check("gap_one_cycle", 32'(bus.m_valid), 0);

    // Overflow: held result not drained while the second frame completes
    bus.m_ready = 1'b0;
    exp_q.push_back(16'hFFFF);
    send_frame(16'hFFFF, 16, -1, 0);
    send_frame(16'h00F0, 16, -1, 0);
    idle(2);
    check("ovf_count",  32'(ovf_cnt),     1);
    check("ovf_serr",   32'(serr_cnt),    0);
    check("ovf_hold",   32'(bus.m_data),  32'hFFFF);
    check("ovf_valid",  32'(bus.m_valid), 1);
    bus.m_ready = 1'b1;
    idle(2);
    check("ovf_drained", 32'(bus.m_valid), 0);

    // Early frame_start at bit 10 aborts the partial frame
    exp_q.push_back(16'hA5A5);
    send_frame(16'hFFFF, 10, -1, 0);
    send_frame(16'hA5A5, 16, -1, 0);
    idle(2);
    check("sync_count", 32'(serr_cnt), 1);
    check("sync_ovf",   32'(ovf_cnt),  1);

    // Back-to-back: drain of the held word coincides with the next frame's last bit
    bus.m_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_frame(16'h1234, 16, -1, 0);
    idle(2);
    b2b = 16'h5678;
    exp_q.push_back(b2b);
    send_frame(b2b, 15, -1, 0);
    bus.m_ready = 1'b1;
    send_bit(b2b[15], 1'b0);
    check("b2b_valid", 32'(bus.m_valid), 1);
    check("b2b_data",  32'(bus.m_data),  32'h5678);
    idle(2);
    check("b2b_ovf",   32'(ovf_cnt),     1);
    check("b2b_drain", 32'(bus.m_valid), 0);

    // Reset mid-frame with a held result, then bits without frame_start are ignored
    bus.m_ready = 1'b0;
    send_frame(16'h1111, 16, -1, 0);
    send_frame(16'h3C3C, 8, -1, 0);
    do_reset();
    check("mid_rst_valid", 32'(bus.m_valid),  0);
    check("mid_rst_data",  32'(bus.m_data),   0);
    check("mid_rst_ovf",   32'(bus.overflow), 0);
    check("mid_rst_serr",  32'(bus.sync_err), 0);
    check("mid_rst_state", 32'(dbg_state),    32'(IDLE));
    bus.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0);
    idle(2);
    check("no_fs_valid", 32'(bus.m_valid), 0);
    check("no_fs_state", 32'(dbg_state),   32'(IDLE));
    exp_q.push_back(16'h0F0F);
    send_frame(16'h0F0F, 16, -1, 0);
    check("post_rst_valid", 32'(bus.m_valid), 1);
    idle(2);

`ifdef COLLECT_PARITY_EN
    exp_q.push_back(16'h8420);
    send_frame(16'h8420, 16, -1, 0);
    check("parity_8420", 32'(bus.m_parity), 1);
    idle(2);
`endif

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
